// File: rtl/lcplc_ctrl_pkg.sv
// Shared types and helpers for the LCPLC band-level control logic.
package lcplc_ctrl_pkg;

  typedef enum logic [1:0] {FILL, WAIT, HDR, DRAIN} seq_state_t;

  // Header layout: {band index, d_flag}
  localparam int HDR_FLAG_POS = 0;
  localparam int HDR_BAND_POS = 1;

  function automatic int band_idx_width(input int bands);
    return (bands > 1) ? $clog2(bands) : 1;
  endfunction

endpackage

// File: rtl/merr_band_buffer.sv
// One band-block of mapped errors: simple dual-port RAM whose registered read
// lands in an output holding register, so data stays put under backpressure.
module merr_band_buffer #(
  parameter int WIDTH     = 19,
  parameter int DEPTH_LOG = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic             rd_last,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready
);

  localparam int DEPTH = 1 << DEPTH_LOG;

  logic [WIDTH-1:0]     mem [0:DEPTH-1];
  logic [DEPTH_LOG-1:0] wr_ptr;
  logic [DEPTH_LOG-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  // read only when the holding register is empty or being consumed
  always_ff @(posedge clk) begin
    if (rd_en) begin
      out_data <= mem[rd_ptr];
      out_last <= rd_last;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      out_valid <= 1'b0;
    end else if (clr) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      out_valid <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) begin
        rd_ptr    <= rd_ptr + 1'b1;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/error_calc_sequencer.sv
// Band-level controller around error_calc: admits one band-block, buffers its
// mapped errors, then emits a header and forwards or discards the band.
module error_calc_sequencer
  import lcplc_ctrl_pkg::*;
#(
  parameter int BANDS          = 224,
  parameter int DATA_WIDTH     = 16,
  parameter int BLOCK_SIZE_LOG = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 x_in_valid,
  output logic                                 x_in_ready,
  input  logic [DATA_WIDTH-1:0]                x_in_data,
  output logic                                 x_out_valid,
  input  logic                                 x_out_ready,
  output logic [DATA_WIDTH-1:0]                x_out_data,
  output logic                                 first_band,
  input  logic                                 merr_in_valid,
  output logic                                 merr_in_ready,
  input  logic [DATA_WIDTH+2:0]                merr_in_data,
  input  logic                                 d_flag_valid,
  output logic                                 d_flag_ready,
  input  logic                                 d_flag_data,
  output logic                                 hdr_valid,
  input  logic                                 hdr_ready,
  output logic [band_idx_width(BANDS):0]       hdr_data,
  output logic                                 merr_out_valid,
  input  logic                                 merr_out_ready,
  output logic [DATA_WIDTH+2:0]                merr_out_data,
  output logic                                 merr_out_last
);

  localparam int              BW        = band_idx_width(BANDS);
  localparam int              CW        = BLOCK_SIZE_LOG + 1;
  localparam logic [CW-1:0]   BLOCK     = CW'(1 << BLOCK_SIZE_LOG);
  localparam logic [CW-1:0]   BLOCK_M1  = CW'((1 << BLOCK_SIZE_LOG) - 1);
  localparam logic [BW-1:0]   LAST_BAND = BW'(BANDS - 1);

  seq_state_t    state;
  logic [CW-1:0] x_cnt, wr_cnt, rd_cnt;
  logic [BW-1:0] band;
  logic          flag;
  logic          first_band_q;

  logic gate_open, x_hs, merr_hs, dflag_hs, hdr_hs, out_hs;
  logic advance, rd_go, rd_en;

  // rst is folded in so every ready reads 0 while reset is held
  assign gate_open     = rst && (state == FILL) && (x_cnt < BLOCK);
  assign x_out_valid   = x_in_valid & gate_open;
  assign x_in_ready    = x_out_ready & gate_open;
  assign x_out_data    = x_in_data;
  assign merr_in_ready = rst && (state == FILL) && (wr_cnt < BLOCK);
  assign d_flag_ready  = (state == WAIT);
  assign hdr_valid     = (state == HDR);
  assign first_band    = first_band_q;

  always_comb begin
    hdr_data               = '0;
    hdr_data[HDR_FLAG_POS] = flag;
    hdr_data[HDR_BAND_POS +: BW] = band;
  end

  assign x_hs     = x_in_valid & x_in_ready;
  assign merr_hs  = merr_in_valid & merr_in_ready;
  assign dflag_hs = d_flag_valid & d_flag_ready;
  assign hdr_hs   = hdr_valid & hdr_ready;
  assign out_hs   = merr_out_valid & merr_out_ready;

  assign advance = (hdr_hs && !flag) || (out_hs && merr_out_last);
  // reading starts on the header handshake so data shows one cycle later
  assign rd_go   = (state == DRAIN) || (hdr_hs && flag);
  assign rd_en   = rd_go && (rd_cnt < BLOCK) && (!merr_out_valid || merr_out_ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= FILL;
      x_cnt        <= '0;
      wr_cnt       <= '0;
      rd_cnt       <= '0;
      band         <= '0;
      flag         <= 1'b0;
      first_band_q <= 1'b1;
    end else begin
      if (x_hs)    x_cnt  <= x_cnt + 1'b1;
      if (merr_hs) wr_cnt <= wr_cnt + 1'b1;
      if (rd_en)   rd_cnt <= rd_cnt + 1'b1;
      case (state)
        FILL:    if (merr_hs && (wr_cnt == BLOCK_M1)) state <= WAIT;
        WAIT:    if (dflag_hs) begin
                   flag  <= d_flag_data;
                   state <= HDR;
                 end
        HDR:     if (hdr_hs) state <= flag ? DRAIN : FILL;
        DRAIN:   if (out_hs && merr_out_last) state <= FILL;
        default: state <= FILL;
      endcase
      if (advance) begin
        x_cnt        <= '0;
        wr_cnt       <= '0;
        rd_cnt       <= '0;
        band         <= (band == LAST_BAND) ? '0 : band + 1'b1;
        first_band_q <= (band == LAST_BAND);
      end
    end
  end

  merr_band_buffer #(
    .WIDTH     (DATA_WIDTH + 3),
    .DEPTH_LOG (BLOCK_SIZE_LOG)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .clr       (advance),
    .wr_en     (merr_hs),
    .wr_data   (merr_in_data),
    .rd_en     (rd_en),
    .rd_last   (rd_cnt == BLOCK_M1),
    .out_valid (merr_out_valid),
    .out_data  (merr_out_data),
    .out_last  (merr_out_last),
    .out_ready (merr_out_ready)
  );

endmodule
